// File: rtl/mm_response_checker.sv
// ----------------------------------------------------------------------------
// mm_response_checker
//
// On-chip response checker for the AND-OR cell y = (a & b) | c. It sits at the
// receiving end of the a/b/c stimulus stream. On every qualified cycle it
// compares y against the golden value and counts mismatches. It records the
// first failing sample and compacts every sample into a 16-bit MISR. After
// NUM_SAMPLES accepted samples it reports done and pass.
//
// Handshake: there is no back-pressure. A sample is consumed on a rising clk
// edge when sample_en is high while the checker is in RUN. sample_en is
// ignored in IDLE and DONE. start is a one-cycle pulse that arms a run from
// IDLE or DONE. start is ignored in RUN; only rst_n aborts a run.
//
// Optional feature macro: MM_CHK_TOGGLE_COV_EN
//   When defined, per-signal rise/fall coverage is collected, and pass also
//   requires full coverage. When undefined, cov_bits is tied to zero.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          arms a run (clears all results)
//   sample_en      qualifies a/b/c/y this cycle
//   a, b, c, y     stimulus bits and DUT output under check
//   busy           high in RUN
//   done           high in DONE (sticky until the next start)
//   pass           done with zero errors (and full coverage when enabled)
//   sample_count   accepted samples this run
//   err_count      mismatches, saturating at all-ones
//   first_err_idx  sample_count value at the first mismatch
//   first_err_vec  {a,b,c,y} at the first mismatch
//   signature      MISR contents
//   cov_bits       {a_rise,a_fall,b_rise,b_fall,c_rise,c_fall,y_rise,y_fall}
// ----------------------------------------------------------------------------
module mm_response_checker #(
  parameter int NUM_SAMPLES = 30,
  parameter int CNT_W       = 8,
  parameter int SIG_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_en,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [3:0]       first_err_vec,
  output logic [SIG_W-1:0] signature,
  output logic [7:0]       cov_bits
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;
  logic [3:0]       fvec_q, fvec_d;
  logic             ferr_q, ferr_d;
  logic [SIG_W-1:0] sig_q, sig_d;

  logic [3:0] vec;
  logic       exp_y;
  logic       mismatch;
  logic       accept;
  logic       arm;
  logic       fb;
  logic       cov_ok;

  assign vec      = {a, b, c, y};
  assign exp_y    = (a & b) | c;
  assign mismatch = (y != exp_y);
  assign accept   = (state_q == ST_RUN) && sample_en;
  // start wins over sample_en outside RUN: the arming cycle never counts.
  assign arm      = start && (state_q != ST_RUN);
  assign fb       = sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10];

`ifdef MM_CHK_TOGGLE_COV_EN
  logic [7:0] cov_q, cov_d;
  logic [3:0] prev_q, prev_d;
  logic       prev_vld_q, prev_vld_d;
  logic [3:0] rise, fall;

  assign rise = ~prev_q & vec;
  assign fall = prev_q & ~vec;

  always_comb begin
    cov_d      = cov_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    if (arm) begin
      cov_d      = 8'h00;
      prev_d     = 4'h0;
      prev_vld_d = 1'b0;
    end else if (accept) begin
      prev_d     = vec;
      prev_vld_d = 1'b1;
      // Edges are only meaningful once a previous sample of this run exists.
      if (prev_vld_q) begin
        cov_d = cov_q | {rise[3], fall[3], rise[2], fall[2],
                         rise[1], fall[1], rise[0], fall[0]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cov_q      <= 8'h00;
      prev_q     <= 4'h0;
      prev_vld_q <= 1'b0;
    end else begin
      cov_q      <= cov_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  assign cov_ok   = (cov_d == 8'hFF);
  assign cov_bits = cov_q;
`else
  assign cov_ok   = 1'b1;
  assign cov_bits = 8'h00;
`endif

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fvec_d  = fvec_q;
    ferr_d  = ferr_q;
    sig_d   = sig_q;
    if (arm) begin
      state_d = ST_RUN;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      cnt_d   = '0;
      err_d   = '0;
      fidx_d  = '0;
      fvec_d  = 4'h0;
      ferr_d  = 1'b0;
      sig_d   = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (mismatch) begin
        if (err_q != '1) begin
          err_d = err_q + CNT_W'(1);
        end
        if (!ferr_q) begin
          ferr_d = 1'b1;
          fidx_d = cnt_q;
          fvec_d = vec;
        end
      end
      sig_d = {sig_q[SIG_W-2:0], fb} ^ SIG_W'(vec);
      // The final sample's counter/signature update and the DONE entry
      // share one edge, so pass is judged on the next-state values.
      if (cnt_q == LAST_IDX) begin
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_d == '0) && cov_ok;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fvec_q  <= 4'h0;
      ferr_q  <= 1'b0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fvec_q  <= fvec_d;
      ferr_q  <= ferr_d;
      sig_q   <= sig_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign sample_count  = cnt_q;
  assign err_count     = err_q;
  assign first_err_idx = fidx_q;
  assign first_err_vec = fvec_q;
  assign signature     = sig_q;

endmodule

// File: doc/mm_response_checker.md
Name: mm_response_checker

Overview:
- On-chip response checker for the multiple_modules AND-OR cell (y = (a & b) | c); the receiving end of the a/b/c stimulus stream.
- Samples the stimulus vector and the DUT output on qualified cycles.
- Compares y against a golden model, counts mismatches and records the first failure.
- Compacts all samples into a MISR signature and reports pass/done after a fixed sample window.
- Sits beside the DUT in synthesis/GLS builds, so a run is self-checking without waveform inspection.

Parameters:
- NUM_SAMPLES, 30, number of accepted samples per run (legal range 1..2^CNT_W-1).
- CNT_W, 8, width of sample and error counters.
- SIG_W, 16, MISR width (fixed polynomial below, valid only for 16).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; arms a run from IDLE or DONE.
- sample_en  input  1  qualifies a/b/c/y sampling this cycle.
- a  input  1  stimulus bit a.
- b  input  1  stimulus bit b.
- c  input  1  stimulus bit c.
- y  input  1  DUT output under check.
- busy  output  1  high in RUN.
- done  output  1  high in DONE; sticky.
- pass  output  1  done & (err_count == 0), plus coverage when enabled.
- sample_count  output  CNT_W  accepted samples this run.
- err_count  output  CNT_W  mismatches; saturates at all-ones.
- first_err_idx  output  CNT_W  sample_count value at the first mismatch.
- first_err_vec  output  4  {a,b,c,y} at the first mismatch.
- signature  output  SIG_W  MISR contents.
- cov_bits  output  8  toggle-coverage flags (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is IDLE.
  - All outputs are 0, signature is 16'h0000, internal first-error flag is cleared.
- FSM:
  - IDLE -> RUN on start. On entry: counters, first_err_*, signature and cov_bits are cleared; done and pass drop.
  - RUN -> DONE on the cycle the NUM_SAMPLES-th sample is accepted.
  - DONE -> RUN on start, with the same clearing as above.
  - start in RUN is ignored; the only abort is reset.
- Sample acceptance:
  - A sample is accepted only when state == RUN and sample_en == 1.
  - sample_en in IDLE or DONE is ignored, and no state changes.
- Per accepted sample (all updates registered, visible the cycle after the sampling edge):
  - exp = (a & b) | c; mismatch = (y != exp).
  - sample_count increments by 1.
  - On mismatch, err_count increments, saturating at 2^CNT_W-1 with no wrap.
  - On the first mismatch of a run, first_err_idx takes the pre-increment sample_count and first_err_vec takes {a,b,c,y}; later mismatches do not overwrite them.
  - MISR update: fb = sig[15]^sig[13]^sig[12]^sig[10]; sig_next = {sig[14:0], fb} ^ {12'b0, a, b, c, y}.
- Final sample and flags:
  - On the final sample, the transition to DONE and the last counter/signature update occur on the same edge.
  - done and pass are valid one cycle after the final sampling edge.
  - busy deasserts on that same edge.
- Simultaneous events:
  - start with sample_en in DONE: the run restarts and the sample is NOT counted; counting begins the next cycle.
  - start with sample_en in IDLE: same rule.
- Reset mid-RUN: immediate return to IDLE with all state cleared; no partial results are retained.
- Inputs are assumed synchronous to clk; no internal synchronisers.

Optional Feature:
- Macro: MM_CHK_TOGGLE_COV_EN.
- Defined:
  - cov_bits = {a_rise, a_fall, b_rise, b_fall, c_rise, c_fall, y_rise, y_fall}.
  - Each bit is set when an accepted sample differs from the previous accepted sample in that direction; the previous-sample register is valid from the second accepted sample of the run.
  - Bits are sticky within a run and cleared on start.
  - pass additionally requires cov_bits == 8'hFF.
- Undefined:
  - cov_bits is tied to 8'h00 and no edge-detect registers are built.
  - pass depends on err_count only.

Test Plan:
- Reset: pulse rst_n low mid-cycle -> all outputs 0 asynchronously, before the next clk edge.
- Clean run:
  - Stimulus: start; 30 sample_en cycles sweeping {a,b,c} through 000..111 cyclically, with y driven by the golden model.
  - Response: done=1, pass=1 (feature off), err_count=0, sample_count=30, busy=0.
  - Signature matches the bench model and is identical across two repeated runs.
- Injected fault:
  - Stimulus: same run with y forced 0 on sample 5, where {a,b,c}=101.
  - Response: err_count=1, first_err_idx=5, first_err_vec=4'b1010, pass=0, and the signature differs from the clean run.
- Qualification and restart:
  - Stimulus: sample_en pulses in IDLE and DONE, then start together with sample_en in DONE.
  - Response: no count changes in IDLE/DONE; after the restart, sample_count=0 on the next cycle and done=0.
- Saturation and mid-run reset:
  - Stimulus: CNT_W=4, NUM_SAMPLES=15 with y always wrong.
  - Response: err_count=15 with no wrap.
  - Then assert rst_n low after sample 7 of a new run -> IDLE, all zeros.
- Coverage (MM_CHK_TOGGLE_COV_EN defined):
  - Clean run without any c falling transition -> cov_bits=8'hFB, pass=0.
  - Full toggle sweep -> cov_bits=8'hFF, pass=1.
